// File: rtl/pipe_pkg.sv
// Shared opcode/funct constants, FSM encoding and result bundle for the
// execute stage and its iterative multiply/divide unit.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] NOP_OP   = 6'b110111;

  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  localparam int unsigned MD_STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } ex_state_e;

  typedef enum logic {
    MD_MUL,
    MD_DIV
  } md_op_e;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  wreg;
    logic        we;
    logic        br_taken;
    logic [31:0] br_target;
  } ex_out_t;

endpackage

// File: rtl/ex_unit_if.sv
// Decode/execute register to execute-stage bus; master is the decode side,
// slave is ex_unit.
interface ex_unit_if;
  logic [31:0] pc_in;
  logic [5:0]  op_in;
  logic [4:0]  rs_in;
  logic [4:0]  rt_in;
  logic [4:0]  rd_in;
  logic [10:0] aux_in;
  logic [31:0] imm_dpl_in;
  logic [25:0] addr_in;
  logic [31:0] os_in;
  logic [31:0] ot_in;

  logic [31:0] result_out;
  logic [4:0]  wreg_out;
  logic        we_out;
  logic        br_taken_out;
  logic [31:0] br_target_out;
  logic        stall_out;

  modport master (
    output pc_in, op_in, rs_in, rt_in, rd_in, aux_in, imm_dpl_in, addr_in, os_in, ot_in,
    input  result_out, wreg_out, we_out, br_taken_out, br_target_out, stall_out
  );

  modport slave (
    input  pc_in, op_in, rs_in, rt_in, rd_in, aux_in, imm_dpl_in, addr_in, os_in, ot_in,
    output result_out, wreg_out, we_out, br_taken_out, br_target_out, stall_out
  );
endinterface

// File: rtl/muldiv_seq.sv
// 32-step unsigned shift-add multiplier / restoring divider sharing one
// 64-bit accumulator: hi = acc[63:32], lo = acc[31:0].
module muldiv_seq
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rstd,
  input  logic        start_i,
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q;
  md_op_e      op_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [32:0] div_diff;

  // A zero divisor never borrows, so the quotient fills with ones and the
  // dividend shifts whole into the remainder without any special case.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    div_sh   = {acc_q[63:32], acc_q[31]};
    div_diff = div_sh - {1'b0, b_q};
    acc_d    = acc_q;
    if (op_q == MD_MUL) begin
      acc_d = {mul_sum, acc_q[31:1]};
    end else if (!div_diff[32]) begin
      acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_d = {div_sh[31:0], acc_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstd) begin
      acc_q  <= '0;
      b_q    <= '0;
      op_q   <= MD_MUL;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        acc_q  <= {32'd0, a_i};
        b_q    <= b_i;
        op_q   <= op_i;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == 5'(MD_STEPS - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = acc_q[63:32];
  assign lo_o   = acc_q[31:0];

endmodule

// File: rtl/ex_unit.sv
// Execute stage: single-cycle ALU/branch decode with registered outputs and a
// stalling iterative MULTU/DIVU path that commits hi/lo in its DONE cycle.
module ex_unit
  import pipe_pkg::*;
(
  input  logic      clk,
  input  logic      rstd,
  ex_unit_if.slave  bus
);

  ex_state_e   state_q;
  ex_out_t     out_q;
  ex_out_t     dec;
  logic [31:0] hi_q, lo_q;
  logic        stall_q;

  logic        start_mul, start_div;
  logic        md_start;
  md_op_e      md_op;
  logic        md_busy_unused;
  logic        md_done;
  logic [31:0] md_hi, md_lo;

  logic [5:0]  funct;
  logic [31:0] os, ot;
  logic        unused_bits;

  assign funct       = bus.aux_in[5:0];
  assign os          = bus.os_in;
  assign ot          = bus.ot_in;
  assign unused_bits = ^{bus.rs_in, bus.aux_in[10:6]};

  always_comb begin
    dec       = '0;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (bus.op_in)
      OP_RTYPE: begin
        dec.wreg = bus.rd_in;
        dec.we   = 1'b1;
        case (funct)
          FN_ADD:   dec.result = os + ot;
          FN_SUB:   dec.result = os - ot;
          FN_AND:   dec.result = os & ot;
          FN_OR:    dec.result = os | ot;
          FN_SLT:   dec.result = {31'd0, $signed(os) < $signed(ot)};
          FN_MFHI:  dec.result = hi_q;
          FN_MFLO:  dec.result = lo_q;
          FN_MULTU: begin
            dec       = '0;
            start_mul = 1'b1;
          end
          FN_DIVU: begin
            dec       = '0;
            start_div = 1'b1;
          end
          default:  dec = '0;
        endcase
      end
      OP_ADDI: begin
        dec.result = os + bus.imm_dpl_in;
        dec.wreg   = bus.rt_in;
        dec.we     = 1'b1;
      end
      OP_BEQ: begin
        dec.br_taken  = (os == ot);
        dec.br_target = bus.pc_in + 32'd4 + {bus.imm_dpl_in[29:0], 2'b00};
      end
      OP_J: begin
        dec.br_taken  = 1'b1;
        dec.br_target = {bus.pc_in[31:28], bus.addr_in, 2'b00};
      end
      default: dec = '0;
    endcase
  end

  assign md_start = (state_q == ST_IDLE) && (start_mul || start_div);
  assign md_op    = start_div ? MD_DIV : MD_MUL;

  muldiv_seq u_muldiv (
    .clk     (clk),
    .rstd    (rstd),
    .start_i (md_start),
    .op_i    (md_op),
    .a_i     (os),
    .b_i     (ot),
    .busy_o  (md_busy_unused),
    .done_o  (md_done),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  // MUL/DIV wait for the sequencer's registered done pulse, which lands one
  // cycle after the 32nd iteration; that extra cycle gives the 34-cycle stall.
  always_ff @(posedge clk) begin
    if (!rstd) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      stall_q <= 1'b0;
    end else begin
      out_q <= '0;
      case (state_q)
        ST_IDLE: begin
          out_q <= dec;
          if (start_mul) begin
            state_q <= ST_MUL;
            stall_q <= 1'b1;
          end else if (start_div) begin
            state_q <= ST_DIV;
            stall_q <= 1'b1;
          end
        end
        ST_MUL, ST_DIV: begin
          if (md_done) state_q <= ST_DONE;
        end
        ST_DONE: begin
          hi_q    <= md_hi;
          lo_q    <= md_lo;
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_out    = out_q.result;
  assign bus.wreg_out      = out_q.wreg;
  assign bus.we_out        = out_q.we;
  assign bus.br_taken_out  = out_q.br_taken;
  assign bus.br_target_out = out_q.br_target;
  assign bus.stall_out     = stall_q;

endmodule

// File: tb/tb_ex_unit.sv
// Randomized and directed checks of ex_unit against an arithmetic reference
// model of the instruction set and the hi/lo registers.
module tb_ex_unit;

  logic clk = 1'b0;
  logic rstd;

  always #5 clk = ~clk;

  ex_unit_if bus();

  ex_unit dut (
    .clk  (clk),
    .rstd (rstd),
    .bus  (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rd,
                       input logic [4:0] rt, input logic [31:0] os, input logic [31:0] ot,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [25:0] addr);
    bus.op_in      = op;
    bus.aux_in     = {5'($urandom), fn};
    bus.rs_in      = 5'($urandom);
    bus.rd_in      = rd;
    bus.rt_in      = rt;
    bus.os_in      = os;
    bus.ot_in      = ot;
    bus.imm_dpl_in = imm;
    bus.pc_in      = pc;
    bus.addr_in    = addr;
  endtask

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 20));
    return 32'($urandom);
  endfunction

  task automatic exec(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rd,
                      input logic [4:0] rt, input logic [31:0] os, input logic [31:0] ot,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [25:0] addr);
    logic        exp_we, exp_br, chk_res, md;
    logic [31:0] exp_res, exp_tgt;
    logic [4:0]  exp_wreg;
    logic [63:0] md_res;
    int unsigned cnt, bad;
    exp_we = 1'b0; exp_br = 1'b0; chk_res = 1'b1; md = 1'b0;
    exp_res = '0; exp_tgt = '0; exp_wreg = '0; md_res = '0;
    if (op == 6'd0) begin
      exp_wreg = rd;
      case (fn)
        6'd32: begin exp_we = 1'b1; exp_res = os + ot; end
        6'd34: begin exp_we = 1'b1; exp_res = os - ot; end
        6'd36: begin exp_we = 1'b1; exp_res = os & ot; end
        6'd37: begin exp_we = 1'b1; exp_res = os | ot; end
        6'd42: begin exp_we = 1'b1; exp_res = ($signed(os) < $signed(ot)) ? 32'd1 : 32'd0; end
        6'd16: begin exp_we = 1'b1; exp_res = m_hi; end
        6'd18: begin exp_we = 1'b1; exp_res = m_lo; end
        6'd25: begin md = 1'b1; chk_res = 1'b0; md_res = {32'd0, os} * {32'd0, ot}; end
        6'd27: begin
          md = 1'b1; chk_res = 1'b0;
          md_res = (ot == 0) ? {os, 32'hFFFF_FFFF} : {os % ot, os / ot};
        end
        default: ;
      endcase
    end else if (op == 6'd8) begin
      exp_we = 1'b1; exp_wreg = rt; exp_res = os + imm;
    end else if (op == 6'd4) begin
      chk_res = 1'b0; exp_br = (os == ot); exp_tgt = pc + 32'd4 + imm * 32'd4;
    end else if (op == 6'd2) begin
      chk_res = 1'b0; exp_br = 1'b1; exp_tgt = {pc[31:28], addr, 2'b00};
    end

    drive(op, fn, rd, rt, os, ot, imm, pc, addr);
    tick();
    check("we", bus.we_out, exp_we);
    if (exp_we) check("wreg", bus.wreg_out, exp_wreg);
    if (chk_res) check("result", bus.result_out, exp_res);
    check("br_taken", bus.br_taken_out, exp_br);
    if (exp_br) check("br_target", bus.br_target_out, exp_tgt);
    check("stall_start", bus.stall_out, md);

    if (md) begin
      cnt = 0; bad = 0;
      while (bus.stall_out === 1'b1 && cnt < 40) begin
        cnt++;
        if (bus.we_out !== 1'b0 || bus.br_taken_out !== 1'b0) bad++;
        if (cnt[0]) drive(6'd0, 6'd32, 5'd9, 5'd9, $urandom, $urandom, $urandom, $urandom, 26'($urandom));
        else        drive(6'd2, 6'd0, 5'd9, 5'd9, $urandom, $urandom, $urandom, $urandom, 26'($urandom));
        tick();
      end
      if (bus.we_out !== 1'b0 || bus.br_taken_out !== 1'b0) bad++;
      check("stall_len", cnt, 34);
      check("stall_bubbles", bad, 0);
      m_hi = md_res[63:32];
      m_lo = md_res[31:0];
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstd = 1'b0;
    drive(6'b110111, 6'd0, 5'd0, 5'd0, '0, '0, '0, '0, '0);
    tick();
    tick();
    check("rst_result", bus.result_out, 0);
    check("rst_wreg", bus.wreg_out, 0);
    check("rst_we", bus.we_out, 0);
    check("rst_br", bus.br_taken_out, 0);
    check("rst_tgt", bus.br_target_out, 0);
    check("rst_stall", bus.stall_out, 0);
    rstd = 1'b1;

    exec(6'd0, 6'd32, 5'd3, 5'd1, 32'd7, 32'd5, '0, '0, '0);
    check("add_dir_res", bus.result_out, 12);
    check("add_dir_wreg", bus.wreg_out, 3);

    exec(6'd0, 6'd25, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd2, '0, '0, '0);
    exec(6'd0, 6'd16, 5'd4, 5'd0, '0, '0, '0, '0, '0);
    check("multu_hi", bus.result_out, 1);
    exec(6'd0, 6'd18, 5'd4, 5'd0, '0, '0, '0, '0, '0);
    check("multu_lo", bus.result_out, 32'hFFFF_FFFE);

    exec(6'd0, 6'd27, 5'd0, 5'd0, 32'd100, 32'd7, '0, '0, '0);
    exec(6'd0, 6'd18, 5'd5, 5'd0, '0, '0, '0, '0, '0);
    check("divu_lo", bus.result_out, 14);
    exec(6'd0, 6'd16, 5'd5, 5'd0, '0, '0, '0, '0, '0);
    check("divu_hi", bus.result_out, 2);

    exec(6'd0, 6'd27, 5'd0, 5'd0, 32'd9, 32'd0, '0, '0, '0);
    exec(6'd0, 6'd18, 5'd6, 5'd0, '0, '0, '0, '0, '0);
    check("div0_lo", bus.result_out, 32'hFFFF_FFFF);
    exec(6'd0, 6'd16, 5'd6, 5'd0, '0, '0, '0, '0, '0);
    check("div0_hi", bus.result_out, 9);

    exec(6'd4, 6'd0, 5'd0, 5'd0, 32'd4, 32'd4, 32'hFFFF_FFFE, 32'h100, '0);
    check("beq_tgt", bus.br_target_out, 32'hFC);
    exec(6'd4, 6'd0, 5'd0, 5'd0, 32'd4, 32'd5, 32'hFFFF_FFFE, 32'h100, '0);
    check("beq_nt", bus.br_taken_out, 0);

    exec(6'b110111, 6'd32, 5'd7, 5'd7, 32'd1, 32'd2, '0, '0, '0);
    check("nop_res", bus.result_out, 0);
    exec(6'd63, 6'd32, 5'd7, 5'd7, 32'd1, 32'd2, '0, '0, '0);
    check("op63_res", bus.result_out, 0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] os, ot, imm, pc;
      logic [5:0]  fn;
      int unsigned k;
      logic [5:0]  fns [7];
      fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd16, 6'd18};
      os = rnd_val(); ot = rnd_val(); imm = 32'($urandom); pc = 32'($urandom);
      k = $urandom_range(0, 39);
      if (k < 14) begin
        fn = fns[k % 7];
        exec(6'd0, fn, 5'($urandom), 5'($urandom), os, ot, imm, pc, 26'($urandom));
      end else if (k < 20) begin
        exec(6'd8, 6'($urandom), 5'($urandom), 5'($urandom), os, ot, imm, pc, 26'($urandom));
      end else if (k < 26) begin
        if (k < 23) ot = os;
        exec(6'd4, 6'($urandom), 5'($urandom), 5'($urandom), os, ot, imm, pc, 26'($urandom));
      end else if (k < 30) begin
        exec(6'd2, 6'($urandom), 5'($urandom), 5'($urandom), os, ot, imm, pc, 26'($urandom));
      end else if (k < 33) begin
        exec(6'($urandom_range(9, 63)), 6'($urandom), 5'($urandom), 5'($urandom), os, ot, imm, pc,
             26'($urandom));
      end else if (k < 36) begin
        exec(6'd0, 6'd1, 5'($urandom), 5'($urandom), os, ot, imm, pc, 26'($urandom));
      end else if (k < 38) begin
        exec(6'd0, 6'd25, 5'd0, 5'd0, os, ot, imm, pc, '0);
      end else begin
        if ($urandom_range(0, 3) == 0) ot = '0;
        exec(6'd0, 6'd27, 5'd0, 5'd0, os, ot, imm, pc, '0);
      end
    end

    exec(6'd0, 6'd25, 5'd0, 5'd0, 32'd3, 32'd5, '0, '0, '0);
    exec(6'd0, 6'd25, 5'd0, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0, '0, '0, '0);
    drive(6'd0, 6'd25, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'h1111_1111, '0, '0, '0);
    tick();
    for (int c = 0; c < 9; c++) begin
      drive(6'b110111, 6'd0, 5'd0, 5'd0, '0, '0, '0, '0, '0);
      tick();
    end
    rstd = 1'b0;
    tick();
    check("abort_stall", bus.stall_out, 0);
    check("abort_we", bus.we_out, 0);
    check("abort_res", bus.result_out, 0);
    rstd = 1'b1;
    m_hi = '0;
    m_lo = '0;
    exec(6'd0, 6'd16, 5'd8, 5'd0, '0, '0, '0, '0, '0);
    check("abort_hi", bus.result_out, 0);
    exec(6'd0, 6'd18, 5'd8, 5'd0, '0, '0, '0, '0, '0);
    check("abort_lo", bus.result_out, 0);
    check("abort_idle", bus.stall_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_unit.md
EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rstd  input  1  reset, synchronous, active-low; sampled only at rising clk.
REQ-003 SHALL have inputs from the decode/execute register: pc_in 32, op_in 6, rs_in 5, rt_in 5, rd_in 5, aux_in 11 (funct = aux_in[5:0]), imm_dpl_in 32 (sign-extended immediate), addr_in 26, os_in 32, ot_in 32.
REQ-004 SHALL have port: result_out  output  32  registered ALU/multiply/divide/move result.
REQ-005 SHALL have port: wreg_out  output  5  registered destination register number.
REQ-006 SHALL have port: we_out  output  1  registered register-write enable.
REQ-007 SHALL have port: br_taken_out  output  1, br_target_out  output  32  registered redirect to fetch.
REQ-008 SHALL have port: stall_out  output  1  high while the multi-cycle unit is busy; upstream holds the next instruction.
REQ-009 SHALL have constant: NOP_OP, 6'b110111, bubble opcode produced by the decode/execute register at reset.

Function
REQ-010 SHALL register every output: an instruction presented in cycle N produces its outputs in cycle N+1.
REQ-011 SHALL decode R-type (op 0) funct: ADD 32, SUB 34, AND 36, OR 37, SLT 42 (signed), MFHI 16, MFLO 18 -> result to rd_in, we_out=1.
REQ-012 SHALL decode ADDI (op 8): os_in+imm_dpl_in to rt_in, we_out=1; arithmetic modulo 2^32, no overflow trap.
REQ-013 SHALL decode BEQ (op 4): br_taken_out=1 when os_in==ot_in, br_target_out=pc_in+4+(imm_dpl_in<<2); we_out=0.
REQ-014 SHALL decode J (op 2): br_taken_out=1, br_target_out={pc_in[31:28],addr_in,2'b00}; we_out=0.
REQ-015 SHALL treat NOP_OP and any undecoded op/funct as a bubble: we_out=0, br_taken_out=0, result_out=0.
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, DONE; IDLE->MUL on MULTU (funct 25), IDLE->DIV on DIVU (funct 27), MUL/DIV->DONE after 32 iteration cycles, DONE->IDLE after one cycle.
REQ-017 SHALL compute MULTU as 32-step shift-add, unsigned: {hi,lo}=os_in*ot_in, operands captured at acceptance.
REQ-018 SHALL compute DIVU as 32-step restoring division, unsigned: lo=quotient, hi=remainder.
REQ-019 SHALL, on DIVU with ot_in==0, set lo=32'hFFFFFFFF, hi=os_in, still taking the full 32 cycles.
REQ-020 SHALL assert stall_out from the cycle after acceptance through the DONE cycle (34 cycles total) and deassert in IDLE.
REQ-021 SHALL ignore all instruction inputs while stall_out is high; outputs are bubbles during MUL/DIV/DONE.
REQ-022 SHALL write hi/lo exactly once, in the DONE cycle; MFHI/MFLO presented in the cycle after stall_out drops returns the new value.
REQ-023 SHALL give MULTU/DIVU we_out=0 and br_taken_out=0.

Reset
REQ-024 SHALL, when rstd=0 at a rising edge, set state=IDLE, hi=lo=0, result_out=0, wreg_out=0, we_out=0, br_taken_out=0, br_target_out=0, stall_out=0.
REQ-025 SHALL abort an in-flight MULTU/DIVU on reset with no hi/lo update.

Structure
REQ-026 SHALL place opcode/funct constants, NOP_OP and FSM state encodings in shared package pipe_pkg.
REQ-027 SHALL implement the iterative multiply/divide datapath as sub-module muldiv_seq (start, op select, operands, busy, done, hi, lo).

Verification
REQ-028 SHALL cover: ADD os=7, ot=5, rd=3 -> next cycle result_out=12, wreg_out=3, we_out=1.
REQ-029 SHALL cover: MULTU os=32'hFFFFFFFF, ot=2 -> stall_out high 34 cycles; then MFHI=1, MFLO=32'hFFFFFFFE.
REQ-030 SHALL cover: DIVU os=100, ot=7 -> MFLO=14, MFHI=2; DIVU os=9, ot=0 -> MFLO=32'hFFFFFFFF, MFHI=9.
REQ-031 SHALL cover: BEQ pc=32'h100, os=ot=4, imm=-2 -> br_taken_out=1, br_target_out=32'hFC; os!=ot -> br_taken_out=0.
REQ-032 SHALL cover: rstd=0 at iteration 10 of MULTU -> stall_out=0 next cycle, MFHI/MFLO return 0.
REQ-033 SHALL cover: op=6'b110111 and op=63 -> we_out=0, br_taken_out=0, result_out=0.
